// File: rtl/nios_debug_vjtag_host.sv
// rtl/nios_debug_vjtag_host.sv - virtual-JTAG initiator for the Nios II debug slave
//
// Purpose: runs one debug command per request through the virtual TAP
// sequence UIR -> CDR -> SDR x SR_LEN -> UDR -> RTI x RTI_CYCLES. It shifts
// cmd_data out on vji_tdi (bit 0 first), captures vji_tdo into rsp_data, and
// samples vji_ir_out during UIR into rsp_ir_out. Everything runs on clk; tck
// is a divided, registered copy of clk.
//
// Ports:
//   clk, reset_n                 system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (cmd_ready = block idle)
//   cmd_ir, cmd_data             IR and shift word, latched on acceptance
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_ir_out         captured shift word and sampled IR status
//   vji_tck, vji_tdi, vji_tdo    generated TAP clock and serial data
//   vji_ir_in, vji_ir_out        IR toward the slave, IR status from the slave
//   vji_uir/cdr/sdr/udr/rti      virtual TAP state strobes

module nios_debug_vjtag_host #(
    parameter int SR_LEN     = 38,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_ir,
    input  logic [SR_LEN-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [SR_LEN-1:0] rsp_data,
    output logic [1:0]        rsp_ir_out,
    output logic              vji_tck,
    output logic              vji_tdi,
    input  logic              vji_tdo,
    output logic [1:0]        vji_ir_in,
    input  logic [1:0]        vji_ir_out,
    output logic              vji_uir,
    output logic              vji_cdr,
    output logic              vji_sdr,
    output logic              vji_udr,
    output logic              vji_rti
);

    localparam int DIV_W   = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int CNT_MAX = (SR_LEN > RTI_CYCLES) ? SR_LEN : RTI_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [CNT_W-1:0] SR_LAST  = CNT_W'(SR_LEN - 1);
    localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_POST,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [DIV_W-1:0]  div_cnt;
    logic              tck_q;
    logic [CNT_W-1:0]  per_cnt;
    logic [SR_LEN-1:0] sh_q;
    logic [SR_LEN-1:0] cap_q;
    logic [1:0]        ir_q;
    logic [1:0]        ir_out_q;

    logic active;
    logic half_end;
    logic tck_rise;
    logic period_end;
    logic accept;

    // tck runs only while walking the TAP states; IDLE and RESP hold it low.
    assign active     = (state != S_IDLE) && (state != S_RESP);
    assign half_end   = active && (div_cnt == DIV_LAST);
    assign tck_rise   = half_end && !tck_q;
    // The end of a high half is also the start of the next low half, which is
    // the only point where strobes, tdi and state may move.
    assign period_end = half_end && tck_q;
    assign accept     = (state == S_IDLE) && cmd_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        vji_uir   = 1'b0;
        vji_cdr   = 1'b0;
        vji_sdr   = 1'b0;
        vji_udr   = 1'b0;
        vji_rti   = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                vji_rti   = 1'b1;
                if (cmd_valid) state_nxt = S_UIR;
            end
            S_UIR: begin
                vji_uir = 1'b1;
                if (period_end) state_nxt = S_CDR;
            end
            S_CDR: begin
                vji_cdr = 1'b1;
                if (period_end) state_nxt = S_SDR;
            end
            S_SDR: begin
                vji_sdr = 1'b1;
                if (period_end && (per_cnt == SR_LAST)) state_nxt = S_UDR;
            end
            S_UDR: begin
                vji_udr = 1'b1;
                if (period_end) state_nxt = S_POST;
            end
            S_POST: begin
                vji_rti = 1'b1;
                if (period_end && (per_cnt == RTI_LAST)) state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                vji_rti   = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            tck_q    <= 1'b0;
            per_cnt  <= '0;
            sh_q     <= '0;
            cap_q    <= '0;
            ir_q     <= 2'b00;
            ir_out_q <= 2'b00;
        end else if (accept) begin
            div_cnt <= '0;
            tck_q   <= 1'b0;
            per_cnt <= '0;
            sh_q    <= cmd_data;
            ir_q    <= cmd_ir;
        end else if (active) begin
            if (half_end) begin
                div_cnt <= '0;
                tck_q   <= ~tck_q;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (tck_rise) begin
                if (state == S_UIR) ir_out_q <= vji_ir_out;
                // LSB-first arrival: after SR_LEN shifts bit i holds slave sr[i].
                if (state == S_SDR) cap_q <= {vji_tdo, cap_q[SR_LEN-1:1]};
            end
            if (period_end) begin
                // per_cnt counts periods within the multi-period states only.
                if (state_nxt != state) per_cnt <= '0;
                else                    per_cnt <= per_cnt + 1'b1;
                if (state == S_SDR) sh_q <= sh_q >> 1;
            end
        end
    end

    assign rsp_data   = cap_q;
    assign rsp_ir_out = ir_out_q;
    assign vji_tck    = tck_q;
    assign vji_tdi    = (state == S_SDR) && sh_q[0];
    assign vji_ir_in  = ir_q;

endmodule

// File: doc/nios_debug_vjtag_host.md
Name: nios_debug_vjtag_host

Overview:
- Initiator end of the Nios II debug-slave virtual-JTAG link, clocked entirely in the system domain.
- Accepts one debug command per request: a 2-bit IR plus an SR_LEN-bit data word.
- Drives the virtual TAP strobes (uir/cdr/sdr/udr/rti), tck and tdi toward the debug slave, shifting the data word in while capturing tdo.
- Returns the captured SR_LEN-bit word and the IR-out status. Used for simulation-driven debug-slave bring-up and for on-chip self-test in place of the sld hub.

Parameters:
- SR_LEN, 38: shift-register length in bits; must match the slave's sr width.
- TCK_DIV, 2: clk cycles per tck half-period; minimum 1.
- RTI_CYCLES, 4: tck periods spent in run-test-idle after each update, giving the slave's sysclk side time to resync and fire take_action.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle; command accepted on cmd_valid&&cmd_ready.
- cmd_ir  in  2  IR value for this command.
- cmd_data  in  SR_LEN  word shifted into the slave, bit 0 first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  SR_LEN  word shifted out of the slave, bit 0 first.
- rsp_ir_out  out  2  vji_ir_out sampled during UIR.
- vji_tck  out  1  generated TAP clock.
- vji_tdi  out  1  serial data to slave.
- vji_tdo  in  1  serial data from slave.
- vji_ir_in  out  2  IR to slave.
- vji_ir_out  in  2  slave IR status.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual TAP state strobes.

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1 and vji_rti=1. State is IDLE.
- Reset is asynchronous and may assert mid-command. Any in-flight command is dropped with no response, tck returns to 0, and ir_in returns to 0.
- tck generation: each tck period is 2*TCK_DIV clk cycles, low half then high half; tck is 0 in IDLE and RESP.
  - All strobes, tdi and ir_in change only at the start of a low half.
  - vji_tdo and vji_ir_out are sampled on the clk edge at which tck goes 0->1.
- State machine (one tck period per state unless stated):
  - IDLE: rti=1, cmd_ready=1. On acceptance, latch cmd_ir and cmd_data, drop cmd_ready, go to UIR.
  - UIR: uir=1; ir_in=cmd_ir, held stable until the next accepted command. rsp_ir_out is sampled here. Next state CDR.
  - CDR: cdr=1 (the slave captures sr). Next state SDR.
  - SDR: sdr=1 for SR_LEN periods.
    - Period i drives tdi=cmd_data[i].
    - Each rising tck shifts the capture register right, with tdo inserted at the MSB.
    - After SR_LEN periods the capture register bit i equals the slave's captured sr[i].
    - Next state UDR.
  - UDR: udr=1. Next state POST.
  - POST: rti=1 for RTI_CYCLES periods, then go to RESP.
  - RESP: rsp_valid=1; rsp_data and rsp_ir_out are stable. On rsp_ready, go to IDLE with cmd_ready=1 on the next cycle.
- Strobe exclusivity: at most one of uir/cdr/sdr/udr is high at any time, and rti is 0 whenever any of them is high.
- Latency: rsp_valid rises exactly (SR_LEN+3+RTI_CYCLES)*2*TCK_DIV clk cycles after the acceptance edge. With defaults this is 45*4 = 180 cycles.
- Response held: if rsp_ready stays low, RESP persists indefinitely; new cmd_valid is ignored (cmd_ready=0).
- Back-to-back commands: rsp_valid and rsp_ready high in the same cycle as a new cmd_valid does not accept the command. It is accepted one cycle later, from IDLE.
- cmd_data and cmd_ir may change after acceptance without effect; the latched copies are used.
- TCK_DIV=1 is legal: tck toggles every clk cycle.

Test Plan:
- Reset, no stimulus -> cmd_ready=1, rti=1, tck=0, rsp_valid=0 for 100 cycles.
- Slave model with sr preloaded 38'h2A_5A5A_5A5A; send cmd_ir=2'b01, cmd_data=38'h15_1234_5678 -> rsp_valid at cycle 180 after acceptance; rsp_data=38'h2A_5A5A_5A5A; slave sr=38'h15_1234_5678 after UDR; ir_in=2'b01.
- Same command with TCK_DIV=1 -> rsp_valid at cycle 90; the tck high count during sdr is exactly 38.
- Strobe monitor across 20 random commands -> no two of uir/cdr/sdr/udr high together; transitions only at tck falling points; order always uir,cdr,sdr×38,udr,rti×4.
- Hold rsp_ready=0 for 50 cycles with cmd_valid=1 -> rsp_data stable and no second command starts; rsp_ready=1 -> cmd_ready=1 next cycle, then the new command is accepted.
- Assert reset_n=0 at the 10th sdr period -> all outputs at reset values on the same edge, no rsp_valid; next command completes normally with correct data.
